if_stage: RTL and testbench
===========================

IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 clk  input  1  sole clock; all state updates on rising edge.
REQ-002 reset  input  1  asynchronous, active-high reset.
REQ-003 stall  input  1  from hazard unit; 1 = hold PC_F and the F/D register.
REQ-004 NPC  input  32  next-PC value from the NPC block; sampled only on a PC update cycle.
REQ-005 PC_F  output  32  current fetch address; also fed back to the NPC block.
REQ-006 im_req  output  1  instruction-memory request strobe.
REQ-007 im_addr  output  32  instruction-memory address; equals PC_F.
REQ-008 im_ready  input  1  memory response valid; variable latency of at least 0 extra cycles (same-cycle response allowed).
REQ-009 im_rdata  input  32  instruction word; valid only while im_ready=1.
REQ-010 PC_D  output  32  PC of the instruction in D.
REQ-011 instr_D  output  32  instruction in D; 0x00000000 (nop) when not valid.
REQ-012 valid_D  output  1  D holds a real instruction.
REQ-013 excAdEL_D  output  1  instruction in D had a fetch address error.

Function
REQ-014 Two-state FSM: FETCH, HOLD.
REQ-015 addr_err = PC_F[1:0]!=0 or PC_F<0x00003000 or PC_F>0x00006FFC.
REQ-016 im_req = (state==FETCH) & ~addr_err; im_addr = PC_F always.
REQ-017 fetch_done = (state==FETCH) & (im_ready | addr_err).
REQ-018 fetch_word = addr_err ? 0x00000000 : im_rdata.
REQ-019 FETCH, fetch_done, stall=0: PC_F<=NPC; F/D<={PC_F, fetch_word, valid=1, exc=addr_err}; stay in FETCH.
REQ-020 FETCH, fetch_done, stall=1: PC_F held; F/D held; capture {PC_F, fetch_word, addr_err} in the hold buffer; go to HOLD.
REQ-021 FETCH, not fetch_done, stall=0: PC_F held; insert a bubble: valid_D<=0, instr_D<=0, excAdEL_D<=0, PC_D held.
REQ-022 FETCH, not fetch_done, stall=1: PC_F and F/D held.
REQ-023 HOLD: im_req=0; im_ready is ignored.
REQ-024 HOLD, stall=1: everything held.
REQ-025 HOLD, stall=0: F/D<=hold buffer with valid=1; PC_F<=NPC; go to FETCH.
REQ-026 PC_F changes only on the update cycles in REQ-019 and REQ-025; NPC is not used in any other cycle.
REQ-027 Each fetched word enters D exactly once; no word is duplicated or dropped under any stall pattern.
REQ-028 No arithmetic on PC in this block; PC+4 is produced by the NPC block.

Reset
REQ-029 On reset=1, the block SHALL immediately (asynchronously) set PC_F=0x00003000, state=FETCH, PC_D=0x00003000, instr_D=0, valid_D=0, excAdEL_D=0, and clear the hold buffer.
REQ-030 A reset during an outstanding request abandons that request; after reset, the first im_ready is treated as the response for 0x00003000.

Structure
REQ-031 Shared package holds: PC_RESET=0x00003000, TEXT_BASE=0x00003000, TEXT_LAST=0x00006FFC, NOP=0x00000000, FSM state encoding.
REQ-032 F/D register is a natural sub-module fd_reg (enable, bubble, and load inputs); the PC register and FSM live in if_stage.

Verification
REQ-033 Reset, then im_ready=1 every cycle, NPC=PC_F+4, stall=0 -> PC_F=0x3000,0x3004,0x3008; PC_D lags PC_F by one cycle; valid_D=1 from the second cycle.
REQ-034 Response latency 2 cycles at 0x3000 -> one bubble cycle with valid_D=0, instr_D=0; word arrives; PC_F becomes 0x3004 exactly once.
REQ-035 im_ready=1 with stall=1 for 3 cycles at PC_F=0x3008 -> state=HOLD, im_req=0, PC_F=0x3008, D unchanged; after stall falls -> instr_D=buffered word, PC_D=0x3008, PC_F=NPC.
REQ-036 NPC=0x00003002 (misaligned) -> next cycle im_req=0; the following D has excAdEL_D=1, instr_D=0, PC_D=0x3002; same for NPC=0x00007000.
REQ-037 Assert reset mid-wait at PC_F=0x3010 -> PC_F=0x3000 and valid_D=0 immediately, without a clock edge; normal fetch resumes from 0x3000.
REQ-038 Random stall and im_ready pattern against a reference model -> the sequence of (PC_D, instr_D) for valid_D=1 matches the fetch order exactly.

Source files
------------

// File: rtl/if_stage_pkg.sv
// rtl/if_stage_pkg.sv - shared constants, FSM encoding and F/D entry type for the fetch stage
package if_stage_pkg;

   localparam logic [31:0] PC_RESET  = 32'h0000_3000;
   localparam logic [31:0] TEXT_BASE = 32'h0000_3000;
   localparam logic [31:0] TEXT_LAST = 32'h0000_6FFC;
   localparam logic [31:0] NOP       = 32'h0000_0000;

   typedef enum logic {
      FETCH = 1'b0,
      HOLD  = 1'b1
   } state_t;

   // One fetched instruction as it travels into the decode stage
   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
      logic        exc;
   } fd_t;

   // Fetch address is legal only when word aligned and inside the text segment
   function automatic logic addr_error(input logic [31:0] pc);
      return (pc[1:0] != 2'b00) || (pc < TEXT_BASE) || (pc > TEXT_LAST);
   endfunction

endpackage

// File: rtl/if_stage_if.sv
// rtl/if_stage_if.sv - instruction-memory request/response bus
interface if_stage_if;

   logic        im_req;
   logic [31:0] im_addr;
   logic        im_ready;
   logic [31:0] im_rdata;

   modport master (
      output im_req,
      output im_addr,
      input  im_ready,
      input  im_rdata
   );

   modport slave (
      input  im_req,
      input  im_addr,
      output im_ready,
      output im_rdata
   );

endinterface

// File: rtl/fd_reg.sv
// rtl/fd_reg.sv - fetch/decode pipeline register with load and bubble control
module fd_reg
   import if_stage_pkg::*;
(
   input  logic clk,
   input  logic reset,
   input  logic enable,
   input  logic bubble,
   input  fd_t  load,
   output fd_t  q,
   output logic valid
);

   // Update only when enabled; a bubble clears the payload but keeps the last PC
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         q.pc    <= PC_RESET;
         q.instr <= NOP;
         q.exc   <= 1'b0;
         valid   <= 1'b0;
      end else if (enable) begin
         if (bubble) begin
            q.instr <= NOP;
            q.exc   <= 1'b0;
            valid   <= 1'b0;
         end else begin
            q     <= load;
            valid <= 1'b1;
         end
      end
   end

endmodule

// File: rtl/if_stage.sv
// rtl/if_stage.sv - instruction fetch stage: PC register, fetch FSM and hold buffer
module if_stage
   import if_stage_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        stall,
   input  logic [31:0] NPC,
   output logic [31:0] PC_F,
   if_stage_if.master  im,
   output logic [31:0] PC_D,
   output logic [31:0] instr_D,
   output logic        valid_D,
   output logic        excAdEL_D
);

   state_t      state;
   state_t      state_next;
   logic [31:0] pc_f;
   logic [31:0] pc_next;
   fd_t         hold_buf;
   logic        buf_load;
   logic        addr_err;
   logic        fetch_done;
   fd_t         fetch_entry;
   logic        fd_enable;
   logic        fd_bubble;
   fd_t         fd_load;
   fd_t         fd_q;

   assign addr_err   = addr_error(pc_f);
   assign fetch_done = (state == FETCH) && (im.im_ready || addr_err);

   // A faulting address never goes to memory; it completes at once as a nop with the error flag
   assign fetch_entry.pc    = pc_f;
   assign fetch_entry.instr = addr_err ? NOP : im.im_rdata;
   assign fetch_entry.exc   = addr_err;

   assign im.im_req  = (state == FETCH) && !addr_err;
   assign im.im_addr = pc_f;

   // Next-state, PC and F/D control; PC only advances when a fetched word moves into D
   always_comb begin
      state_next = state;
      pc_next    = pc_f;
      fd_enable  = 1'b0;
      fd_bubble  = 1'b0;
      fd_load    = fetch_entry;
      buf_load   = 1'b0;
      case (state)
         FETCH: begin
            if (fetch_done) begin
               if (!stall) begin
                  pc_next   = NPC;
                  fd_enable = 1'b1;
               end else begin
                  buf_load   = 1'b1;
                  state_next = HOLD;
               end
            end else if (!stall) begin
               fd_enable = 1'b1;
               fd_bubble = 1'b1;
            end
         end
         HOLD: begin
            if (!stall) begin
               fd_load    = hold_buf;
               fd_enable  = 1'b1;
               pc_next    = NPC;
               state_next = FETCH;
            end
         end
         default: state_next = FETCH;
      endcase
   end

   // State, PC and hold buffer; reset abandons any outstanding request
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state          <= FETCH;
         pc_f           <= PC_RESET;
         hold_buf.pc    <= 32'h0000_0000;
         hold_buf.instr <= NOP;
         hold_buf.exc   <= 1'b0;
      end else begin
         state <= state_next;
         pc_f  <= pc_next;
         if (buf_load) begin
            hold_buf <= fetch_entry;
         end
      end
   end

   fd_reg u_fd_reg (
      .clk    (clk),
      .reset  (reset),
      .enable (fd_enable),
      .bubble (fd_bubble),
      .load   (fd_load),
      .q      (fd_q),
      .valid  (valid_D)
   );

   assign PC_F      = pc_f;
   assign PC_D      = fd_q.pc;
   assign instr_D   = fd_q.instr;
   assign excAdEL_D = fd_q.exc;

endmodule

// File: tb/tb_if_stage.sv
// tb/tb_if_stage.sv - directed and randomized scoreboard bench for if_stage
module tb_if_stage;

   logic        clk = 1'b0;
   logic        reset;
   logic        stall;
   logic [31:0] NPC;
   logic [31:0] PC_F;
   logic [31:0] PC_D;
   logic [31:0] instr_D;
   logic        valid_D;
   logic        excAdEL_D;

   logic        rand_mode   = 1'b0;
   logic        npc_force_en = 1'b0;
   logic [31:0] npc_force   = 32'h0;
   logic [31:0] junk        = 32'hDEAD_BEEF;
   logic        ready_drv   = 1'b0;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] instr;
      logic        exc;
   } exp_t;

   exp_t exp_q[$];

   if_stage_if imem();

   if_stage dut (
      .clk       (clk),
      .reset     (reset),
      .stall     (stall),
      .NPC       (NPC),
      .PC_F      (PC_F),
      .im        (imem),
      .PC_D      (PC_D),
      .instr_D   (instr_D),
      .valid_D   (valid_D),
      .excAdEL_D (excAdEL_D)
   );

   always #5 clk = ~clk;

   // Memory contents: an address-dependent word so a wrong or stale fetch is visible
   function automatic logic [31:0] word_at(input logic [31:0] a);
      return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
   endfunction

   function automatic logic err_at(input logic [31:0] pc);
      return (pc[1:0] != 2'b00) || (pc < 32'h3000) || (pc > 32'h6FFC);
   endfunction

   // Stand-in NPC block: mostly sequential, with jumps to bad and good addresses
   function automatic logic [31:0] next_pc(input logic [31:0] pc);
      logic [31:0] h;
      h = pc * 32'h9E37_79B1;
      h = h ^ (h >> 15);
      if (err_at(pc)) return 32'h3000 + {18'd0, h[13:2], 2'b00};
      case (h[27:24])
         4'd12:   return pc + 32'd2;
         4'd13:   return 32'h7000;
         4'd14:   return 32'h2FFC;
         4'd15:   return 32'h3000 + {18'd0, h[13:2], 2'b00};
         default: return pc + 32'd4;
      endcase
   endfunction

   always_comb begin
      NPC = PC_F + 32'd4;
      if (rand_mode)         NPC = next_pc(PC_F);
      else if (npc_force_en) NPC = npc_force;
   end

   assign imem.im_ready = ready_drv;
   assign imem.im_rdata = imem.im_req ? word_at(imem.im_addr) : junk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic check_d(input string name, input logic [31:0] pc, input logic [31:0] instr,
                          input logic valid, input logic exc);
      check({name, "_pc_d"},  PC_D, pc);
      check({name, "_instr"}, instr_D, instr);
      check({name, "_valid"}, {31'd0, valid_D}, {31'd0, valid});
      check({name, "_exc"},   {31'd0, excAdEL_D}, {31'd0, exc});
   endtask

   // Random stall and memory-response pattern
   always @(negedge clk) begin
      if (rand_mode) begin
         stall     = ($urandom % 4) == 0;
         ready_drv = ($urandom % 2) == 1;
         junk      = $urandom;
      end
   end

   // Scoreboard monitor: D changes only on edges where stall was low
   logic        mon_en = 1'b0;
   int          seen   = 0;
   logic [31:0] last_pc, last_instr;
   logic        last_valid, last_exc;

   always @(posedge clk) begin
      logic st;
      exp_t e;
      if (mon_en) begin
         st = stall;
         #1;
         if (!st) begin
            if (valid_D) begin
               checks++;
               if (exp_q.size() == 0) begin
                  errors++;
                  $display("FAIL sb_underflow: got pc=%h with no expected entry left", PC_D);
               end else begin
                  e = exp_q.pop_front();
                  seen++;
                  if (PC_D !== e.pc || instr_D !== e.instr || excAdEL_D !== e.exc) begin
                     errors++;
                     $display("FAIL sb_entry %0d: got pc=%h instr=%h exc=%b expected pc=%h instr=%h exc=%b",
                              seen, PC_D, instr_D, excAdEL_D, e.pc, e.instr, e.exc);
                  end
               end
            end else begin
               checks++;
               if (instr_D !== 32'h0 || excAdEL_D !== 1'b0) begin
                  errors++;
                  $display("FAIL bubble: got instr=%h exc=%b expected 00000000 0", instr_D, excAdEL_D);
               end
            end
         end else begin
            checks++;
            if (PC_D !== last_pc || instr_D !== last_instr || valid_D !== last_valid || excAdEL_D !== last_exc) begin
               errors++;
               $display("FAIL stall_hold: got pc=%h instr=%h v=%b expected pc=%h instr=%h v=%b",
                        PC_D, instr_D, valid_D, last_pc, last_instr, last_valid);
            end
         end
         last_pc    = PC_D;
         last_instr = instr_D;
         last_valid = valid_D;
         last_exc   = excAdEL_D;
      end
   end

   initial begin
      logic [31:0] mpc;
      exp_t        e;
      int          cyc;

      reset = 1'b1;
      stall = 1'b0;
      ready_drv = 1'b1;
      #1;
      check("rst_pc_f", PC_F, 32'h3000);
      check_d("rst", 32'h3000, 32'h0, 1'b0, 1'b0);
      check("rst_im_req", {31'd0, imem.im_req}, 32'd1);

      // Back-to-back fetches with same-cycle responses
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check("seq_pc_f1", PC_F, 32'h3004);
      check_d("seq1", 32'h3000, word_at(32'h3000), 1'b1, 1'b0);
      @(negedge clk);
      check("seq_pc_f2", PC_F, 32'h3008);
      check_d("seq2", 32'h3004, word_at(32'h3004), 1'b1, 1'b0);

      // Response arrives while stalled: word parks in the hold buffer
      stall = 1'b1;
      repeat (3) begin
         @(negedge clk);
         check("hold_im_req", {31'd0, imem.im_req}, 32'd0);
         check("hold_pc_f", PC_F, 32'h3008);
         check_d("hold", 32'h3004, word_at(32'h3004), 1'b1, 1'b0);
      end
      stall = 1'b0;
      @(negedge clk);
      check("unhold_pc_f", PC_F, 32'h300C);
      check_d("unhold", 32'h3008, word_at(32'h3008), 1'b1, 1'b0);

      // Two-cycle latency: one bubble, then the word, PC advances once
      ready_drv = 1'b0;
      @(negedge clk);
      check("lat_pc_f", PC_F, 32'h300C);
      check_d("lat_bubble", 32'h3008, 32'h0, 1'b0, 1'b0);
      ready_drv = 1'b1;
      @(negedge clk);
      check("lat_pc_f2", PC_F, 32'h3010);
      check_d("lat_word", 32'h300C, word_at(32'h300C), 1'b1, 1'b0);

      // Misaligned and out-of-segment fetch addresses
      npc_force_en = 1'b1;
      npc_force    = 32'h3002;
      @(negedge clk);
      check("mis_pc_f", PC_F, 32'h3002);
      check("mis_im_req", {31'd0, imem.im_req}, 32'd0);
      npc_force = 32'h7000;
      @(negedge clk);
      check_d("mis", 32'h3002, 32'h0, 1'b1, 1'b1);
      check("oob_im_req", {31'd0, imem.im_req}, 32'd0);
      npc_force = 32'h3010;
      @(negedge clk);
      check_d("oob", 32'h7000, 32'h0, 1'b1, 1'b1);
      check("oob_pc_f", PC_F, 32'h3010);

      // Asynchronous reset while a request is outstanding
      npc_force_en = 1'b0;
      ready_drv    = 1'b0;
      @(negedge clk);
      #2;
      reset = 1'b1;
      #1;
      check("arst_pc_f", PC_F, 32'h3000);
      check_d("arst", 32'h3000, 32'h0, 1'b0, 1'b0);
      @(negedge clk);
      reset     = 1'b0;
      ready_drv = 1'b1;
      @(negedge clk);
      check("arst_resume_pc_f", PC_F, 32'h3004);
      check_d("arst_resume", 32'h3000, word_at(32'h3000), 1'b1, 1'b0);

      // Randomized run against the fetch-order model
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      mpc = 32'h3000;
      for (int i = 0; i < 1500; i++) begin
         e.pc    = mpc;
         e.exc   = err_at(mpc);
         e.instr = e.exc ? 32'h0 : word_at(mpc);
         exp_q.push_back(e);
         mpc = next_pc(mpc);
      end
      stall      = 1'b0;
      ready_drv  = 1'b0;
      last_pc    = PC_D;
      last_instr = instr_D;
      last_valid = valid_D;
      last_exc   = excAdEL_D;
      rand_mode  = 1'b1;
      mon_en     = 1'b1;
      cyc = 0;
      while (seen < 600 && cyc < 20000) begin
         @(negedge clk);
         cyc++;
      end
      checks++;
      if (seen < 600) begin
         errors++;
         $display("FAIL progress: got %0d instructions expected 600 within budget", seen);
      end
      mon_en    = 1'b0;
      rand_mode = 1'b0;
      @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
